// File: rtl/direction_ctrl_if.sv
// Button, counter-feedback and direction bundle for direction_ctrl.
// master drives buttons and q_in; slave returns d and dir_pulse.
interface direction_ctrl_if #(
  parameter int Q_W = 3
);
  logic           btn_up;
  logic           btn_dn;
  logic [Q_W-1:0] q_in;
  logic           d;
  logic           dir_pulse;

  modport master (
    output btn_up,
    output btn_dn,
    output q_in,
    input  d,
    input  dir_pulse
  );

  modport slave (
    input  btn_up,
    input  btn_dn,
    input  q_in,
    output d,
    output dir_pulse
  );
endinterface

// File: rtl/direction_ctrl.sv
// Debounced up/down direction control for an up/down counter.
// Define AUTO_REVERSE_EN to make the counter ping-pong instead of wrap.
module direction_ctrl #(
  parameter int DB_CYCLES = 4,
  parameter int Q_W       = 3
) (
  input logic            clk,
  input logic            rst,
  direction_ctrl_if.slave bus
);
  typedef enum logic {
    DOWN = 1'b0,
    UP   = 1'b1
  } state_t;

  localparam logic [7:0] DB_LAST = 8'(DB_CYCLES - 1);

  // index 0 = up button, index 1 = dn button
  logic [1:0] btn;
  logic [1:0] s1;
  logic [1:0] s2;
  logic [1:0] stb;
  logic [1:0] stb_q;
  logic [1:0] rise;
  logic [7:0] cnt [2];

  state_t state;
  logic   d_q;
  logic   pulse_q;
  logic   up_ev;
  logic   dn_ev;
  logic   btn_turn;
  logic   turn;

  assign btn = {bus.btn_dn, bus.btn_up};

  always_ff @(posedge clk) begin
    if (rst) begin
      s1     <= '0;
      s2     <= '0;
      stb    <= '0;
      stb_q  <= '0;
      cnt[0] <= '0;
      cnt[1] <= '0;
    end else begin
      s1    <= btn;
      s2    <= s1;
      stb_q <= stb;
      for (int i = 0; i < 2; i++) begin
        if (s2[i] == stb[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == DB_LAST) begin
          stb[i] <= s2[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + 8'd1;
        end
      end
    end
  end

  assign rise  = stb & ~stb_q;
  assign up_ev = rise[0];
  assign dn_ev = rise[1];

  // simultaneous presses cancel; same-direction presses do nothing
  assign btn_turn = (up_ev ^ dn_ev) &
                    ((state == UP) ? dn_ev : up_ev);

`ifdef AUTO_REVERSE_EN
  localparam logic [Q_W-1:0] Q_TOP = {{(Q_W-1){1'b1}}, 1'b0};
  localparam logic [Q_W-1:0] Q_ONE = Q_W'(1);

  logic auto_hit;

  assign auto_hit = ((state == UP)   && (bus.q_in == Q_TOP)) ||
                    ((state == DOWN) && (bus.q_in == Q_ONE));

  always_comb begin
    turn = 1'b0;
    if (auto_hit) turn = 1'b1;
    else          turn = btn_turn;
  end
`else
  logic unused_q_in;

  assign unused_q_in = ^bus.q_in;

  always_comb begin
    turn = 1'b0;
    turn = btn_turn;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= UP;
      d_q     <= 1'b1;
      pulse_q <= 1'b0;
    end else begin
      pulse_q <= turn;
      unique case (state)
        UP: if (turn) begin
          state <= DOWN;
          d_q   <= 1'b0;
        end
        DOWN: if (turn) begin
          state <= UP;
          d_q   <= 1'b1;
        end
        default: begin
          state <= UP;
          d_q   <= 1'b1;
        end
      endcase
    end
  end

  assign bus.d         = d_q;
  assign bus.dir_pulse = pulse_q;
endmodule

// File: tb/tb_direction_ctrl.sv
// Directed bench for direction_ctrl with a paired up/down counter.
// Define AUTO_REVERSE_EN for both RTL and bench to check ping-pong.
module tb_direction_ctrl;
  localparam int DB = 4;
  localparam int QW = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  direction_ctrl_if #(.Q_W(QW)) bus ();

  direction_ctrl #(
    .DB_CYCLES(DB),
    .Q_W(QW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  logic [QW-1:0] q;
  logic          paired = 1'b0;

  always @(posedge clk) begin
    if (rst) q <= '0;
    else     q <= bus.d ? q + 1'b1 : q - 1'b1;
  end

  assign bus.q_in = paired ? q : QW'(3);

  int total = 0;
  int bad   = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // d and pulse over edges 0..7 after a held press that flips direction
  task automatic chk_flip(input string nm, input logic new_d);
    logic ed;
    logic ep;
    for (int k = 0; k < 8; k++) begin
      tick();
      ed = (k < DB + 2) ? ~new_d : new_d;
      ep = (k == DB + 2);
      total++;
      if (bus.d !== ed) begin
        bad++;
        $display("FAIL %s d edge=%0d got=%b exp=%b", nm, k, bus.d, ed);
      end
      total++;
      if (bus.dir_pulse !== ep) begin
        bad++;
        $display("FAIL %s pulse edge=%0d got=%b exp=%b",
                 nm, k, bus.dir_pulse, ep);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.btn_up = 1'b1;
    bus.btn_dn = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      total++;
      if (bus.d !== 1'b1 || bus.dir_pulse !== 1'b0) begin
        bad++;
        $display("FAIL reset_hold d=%b pulse=%b exp d=1 pulse=0",
                 bus.d, bus.dir_pulse);
      end
    end
    rst = 1'b0;
    bus.btn_up = 1'b0;
    chk_flip("reset_release_dn", 1'b0);
    bus.btn_dn = 1'b0;
    idle(10);
  endtask

  task automatic test_debounce();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.btn_dn = 1'b1;
    idle(3);
    bus.btn_dn = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      total++;
      if (bus.d !== 1'b1 || bus.dir_pulse !== 1'b0) begin
        bad++;
        $display("FAIL short_glitch d=%b pulse=%b exp d=1 pulse=0",
                 bus.d, bus.dir_pulse);
      end
    end
    bus.btn_dn = 1'b1;
    chk_flip("debounce_dn", 1'b0);
    bus.btn_dn = 1'b0;
    idle(10);
  endtask

  task automatic test_bounce();
    for (int i = 0; i < 20; i++) begin
      bus.btn_up = (i % 2 == 0);
      tick();
      total++;
      if (bus.d !== 1'b0 || bus.dir_pulse !== 1'b0) begin
        bad++;
        $display("FAIL bounce d=%b pulse=%b exp d=0 pulse=0",
                 bus.d, bus.dir_pulse);
      end
    end
    bus.btn_up = 1'b0;
    idle(4);
    bus.btn_up = 1'b1;
    chk_flip("bounce_then_hold", 1'b1);
    bus.btn_up = 1'b0;
    idle(10);
  endtask

  task automatic test_simultaneous();
    bus.btn_up = 1'b1;
    bus.btn_dn = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      total++;
      if (bus.d !== 1'b1 || bus.dir_pulse !== 1'b0) begin
        bad++;
        $display("FAIL both_pressed d=%b pulse=%b exp d=1 pulse=0",
                 bus.d, bus.dir_pulse);
      end
    end
    bus.btn_up = 1'b0;
    bus.btn_dn = 1'b0;
    idle(10);
    bus.btn_up = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      total++;
      if (bus.d !== 1'b1 || bus.dir_pulse !== 1'b0) begin
        bad++;
        $display("FAIL same_dir d=%b pulse=%b exp d=1 pulse=0",
                 bus.d, bus.dir_pulse);
      end
    end
    bus.btn_up = 1'b0;
    idle(10);
  endtask

  task automatic test_rst_priority();
    bus.btn_dn = 1'b1;
    idle(3);
    rst = 1'b1;
    tick();
    total++;
    if (bus.d !== 1'b1 || bus.dir_pulse !== 1'b0) begin
      bad++;
      $display("FAIL mid_debounce_rst d=%b pulse=%b exp d=1 pulse=0",
               bus.d, bus.dir_pulse);
    end
    rst = 1'b0;
    chk_flip("restart_after_rst", 1'b0);
    bus.btn_dn = 1'b0;
    idle(10);
  endtask

  task automatic test_counter();
    logic [QW-1:0] eq;
    logic          ed;
    logic          ep;
    int            m;
    bus.btn_up = 1'b0;
    bus.btn_dn = 1'b0;
    paired = 1'b1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int t = 0; t <= 40; t++) begin
      if (t > 0) tick();
`ifdef AUTO_REVERSE_EN
      m  = t % 14;
      eq = QW'((m <= 7) ? m : 14 - m);
      ed = (m < 7);
      ep = (t > 0) && (t % 7 == 0);
`else
      m  = t % 8;
      eq = QW'(m);
      ed = 1'b1;
      ep = 1'b0;
`endif
      total++;
      if (q !== eq || bus.d !== ed || bus.dir_pulse !== ep) begin
        bad++;
        $display("FAIL counter t=%0d q=%0d d=%b p=%b exp q=%0d d=%b p=%b",
                 t, q, bus.d, bus.dir_pulse, eq, ed, ep);
      end
    end
    paired = 1'b0;
  endtask

  initial begin
    bus.btn_up = 1'b0;
    bus.btn_dn = 1'b0;
    test_reset();
    test_debounce();
    test_bounce();
    test_simultaneous();
    test_rst_priority();
    test_counter();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
